// File: rtl/fpmul_seq_if.sv
// fpmul_seq_if: operand/result handshake bundle for fpmul_seq.
// Master drives start/a/b; slave returns ready/done/result/flags.
interface fpmul_seq_if #(
  parameter int EW = 8,
  parameter int MW = 23
);
  localparam int W = 1 + EW + MW;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] rez;
  logic         ovf;
  logic         unf;

  modport master (
    output start, a, b,
    input  ready, done, rez, ovf, unf
  );

  modport slave (
    input  start, a, b,
    output ready, done, rez, ovf, unf
  );
endinterface

// File: rtl/fpmul_seq.sv
// fpmul_seq: iterative shift-add floating-point multiplier, start/done handshake.
// Define FPMUL_ROUND_EN for round-to-nearest-even; otherwise results truncate.
module fpmul_seq #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input logic        clk,
  input logic        reset,
  fpmul_seq_if.slave bus
);
  localparam int W  = 1 + EW + MW;
  localparam int XW = EW + 2;
  localparam int PW = 2 * MW + 2;
  localparam int CW = $clog2(MW + 1);

  localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX  = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] EZERO = '0;
  localparam logic [CW-1:0]        CNT0  = CW'(MW);

`ifdef FPMUL_ROUND_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_NORM, S_RND, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_NUM, K_ZERO, K_INF, K_NAN
  } kind_t;

  state_t                 state_q, state_d;
  kind_t                  kind_q, kind_d;
  logic                   sign_q, sign_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic [MW:0]            ma_q, ma_d;
  logic [MW:0]            mb_q, mb_d;
  logic [PW-1:0]          prod_q, prod_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MW-1:0]          frac_q, frac_d;
  logic                   grd_q, grd_d;
  logic                   stk_q, stk_d;
  logic [W-1:0]           rez_q, rez_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   done_q, done_d;

  logic [EW-1:0] ea, eb;
  logic          za, zb, ia, ib;
  logic [PW:0]   sum;
  logic [PW-1:0] pn;
  logic          inc;
  logic [MW:0]   rnd;

  assign ea = bus.a[W-2:MW];
  assign eb = bus.b[W-2:MW];
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = &ea;
  assign ib = &eb;

  // Right-shifting accumulator: add A at the top, then drop one bit.
  assign sum = {1'b0, prod_q}
             + (mb_q[0] ? {1'b0, ma_q, {(MW+1){1'b0}}} : '0);
  assign pn  = prod_q[PW-1] ? prod_q : (prod_q << 1);
  assign inc = RND_EN & grd_q & (stk_q | frac_q[0]);
  assign rnd = {1'b0, frac_q} + {{MW{1'b0}}, inc};

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    frac_d  = frac_q;
    grd_d   = grd_q;
    stk_d   = stk_q;
    rez_d   = rez_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sign_d  = bus.a[W-1] ^ bus.b[W-1];
          exp_d   = $signed({2'b00, ea})
                  + $signed({2'b00, eb}) - BIAS;
          ma_d    = {1'b1, bus.a[MW-1:0]};
          mb_d    = {1'b1, bus.b[MW-1:0]};
          prod_d  = '0;
          cnt_d   = CNT0;
          state_d = S_MUL;
          if ((ia && zb) || (ib && za)) kind_d = K_NAN;
          else if (za || zb)            kind_d = K_ZERO;
          else if (ia || ib)            kind_d = K_INF;
          else                          kind_d = K_NUM;
        end
      end
      S_MUL: begin
        prod_d = sum[PW:1];
        mb_d   = mb_q >> 1;
        if (cnt_q == '0) state_d = S_NORM;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_NORM: begin
        frac_d  = pn[PW-2:MW+1];
        grd_d   = pn[MW];
        stk_d   = |pn[MW-1:0];
        exp_d   = exp_q + {{(XW-1){1'b0}}, prod_q[PW-1]};
        state_d = S_RND;
      end
      S_RND: begin
        frac_d = rnd[MW-1:0];
        if (rnd[MW]) exp_d = exp_q + XW'(1);
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        state_d = S_IDLE;
        unique case (kind_q)
          K_NAN:  rez_d = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
          K_ZERO: rez_d = {sign_q, {(W-1){1'b0}}};
          K_INF:  rez_d = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
          K_NUM: begin
            if (exp_q >= EMAX) begin
              rez_d = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
              ovf_d = 1'b1;
            end else if (exp_q <= EZERO) begin
              rez_d = {sign_q, {(W-1){1'b0}}};
              unf_d = 1'b1;
            end else begin
              rez_d = {sign_q, exp_q[EW-1:0], frac_q};
            end
          end
          default: rez_d = rez_q;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_NUM;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      frac_q  <= '0;
      grd_q   <= 1'b0;
      stk_q   <= 1'b0;
      rez_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      frac_q  <= frac_d;
      grd_q   <= grd_d;
      stk_q   <= stk_d;
      rez_q   <= rez_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.done  = done_q;
  assign bus.rez   = rez_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule
